// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcodes, scheduler FSM states and opcode legality check
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] OP_RST  = 3'b000;
  localparam logic [2:0] OP_NOR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_RUN  = 3'd2,
    ST_CAPT = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return (op >= OP_NOR) && (op <= OP_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_serial_sched_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin grant, search starts one past the last winner
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDW   = 1
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDW-1:0]   last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_idx,
  output logic             gnt_any
);

  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(last_grant) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = j[IDW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_serial_sched.sv
// ============================================================================
// alu_serial_sched : shares one bit-serial ALU among N_REQ requesters.
// Optional overflow flag output enabled by macro ALU_SEQ_OVF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_serial_sched
  import alu_pkg::*;
#(
  parameter int  WIDTH = 4,
  parameter int  N_REQ = 2,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_srcA,
  input  logic [N_REQ*WIDTH-1:0] req_srcB,
  input  logic [N_REQ*3-1:0]     req_op,
  output logic [WIDTH-1:0]       alu_srcA,
  output logic [WIDTH-1:0]       alu_srcB,
  output logic [2:0]             alu_opCode,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_zero,
  input  logic                   alu_carry,
  input  logic                   alu_sign,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_zero,
  output logic                   rsp_carry,
  output logic                   rsp_sign,
`ifdef ALU_SEQ_OVF_EN
  output logic                   rsp_ovf,
`endif
  output logic                   rsp_err
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] src_a_q, src_a_d, src_b_q, src_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d, rsp_carry_q, rsp_carry_d;
  logic             rsp_sign_q, rsp_sign_d, rsp_err_q, rsp_err_d;
`ifdef ALU_SEQ_OVF_EN
  logic             rsp_ovf_q, rsp_ovf_d;
`endif

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req_valid (req_valid),
    .last_grant(last_grant_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

  // Ready is held low while reset is asserted so no handshake can be seen.
  assign req_ready = (state_q == ST_IDLE && !reset) ? gnt : '0;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    alu_op_d     = alu_op_q;
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_sign_d   = rsp_sign_q;
    rsp_err_d    = rsp_err_q;
`ifdef ALU_SEQ_OVF_EN
    rsp_ovf_d    = rsp_ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          src_a_d      = req_srcA[gnt_idx*WIDTH +: WIDTH];
          src_b_d      = req_srcB[gnt_idx*WIDTH +: WIDTH];
          op_d         = req_op[gnt_idx*3 +: 3];
          last_grant_d = gnt_idx;
          rsp_id_d     = gnt_idx;
          if (op_legal(req_op[gnt_idx*3 +: 3])) begin
            state_d = ST_SYNC;
          end else begin
            state_d      = ST_RESP;
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            rsp_carry_d  = 1'b0;
            rsp_sign_d   = 1'b0;
`ifdef ALU_SEQ_OVF_EN
            rsp_ovf_d    = 1'b0;
`endif
          end
        end
      end
      ST_SYNC: begin
        alu_op_d = op_q;
        beat_d   = '0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (beat_q == BW'(WIDTH-1)) begin
          alu_op_d = OP_RST;
          beat_d   = '0;
          state_d  = ST_CAPT;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      ST_CAPT: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_carry_d  = alu_carry;
        rsp_sign_d   = alu_sign;
        rsp_err_d    = 1'b0;
`ifdef ALU_SEQ_OVF_EN
        // Signed overflow from operand and result sign bits only.
        rsp_ovf_d = ((op_q == OP_ADD) && (src_a_q[WIDTH-1] == src_b_q[WIDTH-1])
                     && (alu_result[WIDTH-1] != src_a_q[WIDTH-1]))
                 || ((op_q == OP_SUB) && (src_a_q[WIDTH-1] != src_b_q[WIDTH-1])
                     && (alu_result[WIDTH-1] != src_a_q[WIDTH-1]));
`endif
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      last_grant_q <= IDW'(N_REQ-1);
      op_q         <= OP_RST;
      alu_op_q     <= OP_RST;
      src_a_q      <= '0;
      src_b_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_sign_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      rsp_ovf_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      alu_op_q     <= alu_op_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_sign_q   <= rsp_sign_d;
      rsp_err_q    <= rsp_err_d;
`ifdef ALU_SEQ_OVF_EN
      rsp_ovf_q    <= rsp_ovf_d;
`endif
    end
  end

  assign alu_srcA   = src_a_q;
  assign alu_srcB   = src_b_q;
  assign alu_opCode = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_sign   = rsp_sign_q;
  assign rsp_err    = rsp_err_q;
`ifdef ALU_SEQ_OVF_EN
  assign rsp_ovf    = rsp_ovf_q;
`endif

endmodule

`default_nettype wire
